restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's multiplier datapath.
- Takes a dividend and divisor and iterates one quotient bit per clock using a trial subtract.
- Returns quotient and remainder with a start/busy/done handshake.
- Sits beside the multiplier as the division unit of the arithmetic block.

Parameters:
WIDTH, 4, operand/result width in bits (WIDTH >= 2)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a division; sampled only when busy=0
dividend  input  WIDTH  unsigned dividend, sampled with start
divisor  input  WIDTH  unsigned divisor, sampled with start
quotient  output  WIDTH  registered quotient, held until next result
remainder  output  WIDTH  registered remainder, held until next result
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse: quotient/remainder/div_by_zero valid
div_by_zero  output  1  registered flag, valid with done, held until next result

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset (any state, including mid-division) forces state IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; internal A, Q, M and count cleared.
  - An in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN, DZ.
- IDLE, start=1 at edge E0:
  - divisor != 0: A=0 (WIDTH+1 bits), Q=dividend, M=divisor, count=WIDTH, busy=1, go to RUN.
  - divisor == 0: go to DZ, busy=1.
  - start=0: stay in IDLE.
- RUN, each edge, one iteration:
  - {A,Q} shifted left 1 (Q[0] vacated); T = A_shifted - {0,M} at WIDTH+1 bits.
  - T MSB=0: A=T, Q[0]=1. Otherwise A unchanged (restore), Q[0]=0.
  - count decrements.
  - On the iteration where count goes 1->0: quotient=new Q, remainder=new A[WIDTH-1:0], div_by_zero=0, done=1, busy=0, go to IDLE.
  - Latency: done high exactly WIDTH cycles after E0 (WIDTH edges in RUN).
- DZ, one edge:
  - quotient=all ones, remainder=dividend as sampled at E0, div_by_zero=1, done=1, busy=0, go to IDLE.
  - Latency: 1 cycle.
- done:
  - Deasserts on the following edge unless reasserted by a new completion.
  - Never high for two consecutive cycles from one operation.
- start while busy=1: ignored. Operands are not resampled and the operation is unaffected.
- start in the same cycle done=1 (state IDLE): accepted as a new operation. quotient/remainder keep the just-completed values until the new completion.
- Operands are latched at E0; changing dividend/divisor during RUN has no effect.
- Arithmetic:
  - Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
  - All values unsigned; no signed mode.
  - The WIDTH+1-bit A prevents overflow on the trial subtract when divisor MSB=1.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=4, dividend=13, divisor=4, start for 1 cycle -> busy=1 for 4 cycles; done pulse 4 cycles after start edge with quotient=3, remainder=1, div_by_zero=0; outputs held afterwards.
- dividend=15, divisor=1 -> quotient=15, remainder=0. dividend=3, divisor=7 -> quotient=0, remainder=3. dividend=15, divisor=8 (divisor MSB set) -> quotient=1, remainder=7.
- dividend=9, divisor=0 -> done one cycle after start edge; quotient=15, remainder=9, div_by_zero=1. A following 6/3 -> quotient=2, remainder=0, div_by_zero=0.
- Start 14/3, then pulse start with 5/5 two cycles later while busy=1 -> second start ignored; done once with quotient=4, remainder=2.
- Start 14/3, assert rst 2 cycles later -> next edge: busy=0, done=0, quotient=0, remainder=0, no done pulse. A subsequent 7/2 -> quotient=3, remainder=1.
- Back-to-back: start 12/5, hold start=1 with 10/3 in the done cycle -> first done gives quotient=2, remainder=2; second done 4 cycles later gives quotient=3, remainder=1. Exhaustive sweep of all 256 WIDTH=4 pairs against a reference model.

Source files
------------

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider
//  Purpose  : Sequential unsigned restoring divider, one quotient bit per clock,
//             with a start/busy/done handshake and divide-by-zero reporting.
//  Revision : 1.0  initial release
// ============================================================================
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_ITERATIONS = CW'(WIDTH);
    localparam logic [CW-1:0] C_LAST       = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DZ   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    // The partial remainder always ends an iteration below the divisor, so it
    // is stored in WIDTH bits; the extra bit is only needed for the trial
    // subtract, where the shifted value can reach 2*divisor-1.
    logic [WIDTH:0]   a_shift_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] q_d;
    logic [CW-1:0]    cnt_d;

    assign a_shift_d = {a_q, q_q[WIDTH-1]};
    assign trial_d   = a_shift_d - {1'b0, m_q};
    assign a_d       = trial_d[WIDTH] ? a_shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    assign q_d       = {q_q[WIDTH-2:0], ~trial_d[WIDTH]};
    assign cnt_d     = cnt_q - C_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Dividend goes into Q either way so DZ can return it.
                        a_q    <= '0;
                        q_q    <= dividend;
                        m_q    <= divisor;
                        cnt_q  <= C_ITERATIONS;
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            state_q <= S_DZ;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == C_LAST) begin
                        quotient_q  <= q_d;
                        remainder_q <= a_d;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_DZ: begin
                    quotient_q  <= '1;
                    remainder_q <= q_q;
                    dbz_q       <= 1'b1;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_restoring_divider
//  Purpose  : Self-checking bench for restoring_divider against an arithmetic
//             reference model (directed cases, exhaustive sweep, random ops).
//  Revision : 1.0  initial release
// ============================================================================
module tb_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    restoring_divider #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero returns all ones and
    // the dividend after a single cycle.
    function automatic void model(input int dd, input int dv,
                                  output int q, output int r, output int dz, output int lat);
        if (dv == 0) begin
            q = (1 << W) - 1; r = dd; dz = 1; lat = 1;
        end else begin
            q = dd / dv; r = dd % dv; dz = 0; lat = W;
        end
    endfunction

    task automatic launch(input int dd, input int dv);
        start    = 1'b1;
        dividend = W'(dd);
        divisor  = W'(dv);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit scramble);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (scramble) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
    endtask

    task automatic check_result(input string tag, input int dd, input int dv);
        int q, r, dz, lat;
        model(dd, dv, q, r, dz, lat);
        check({tag, " quotient"}, quotient, q);
        check({tag, " remainder"}, remainder, r);
        check({tag, " div_by_zero"}, div_by_zero, dz);
        check({tag, " busy_at_done"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input int dd, input int dv, input bit scramble);
        int q, r, dz, lat;
        model(dd, dv, q, r, dz, lat);
        launch(dd, dv);
        check({tag, " busy_after_start"}, busy, 1);
        wait_done(tag, lat, scramble);
        check_result(tag, dd, dv);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " quotient_held"}, quotient, q);
        check({tag, " remainder_held"}, remainder, r);
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, including divisor MSB set and divide by zero.
        run_op("13/4", 13, 4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("13/4 long_hold quotient", quotient, 3);
        run_op("15/1", 15, 1, 1'b0);
        run_op("3/7", 3, 7, 1'b0);
        run_op("15/8", 15, 8, 1'b0);
        run_op("9/0", 9, 0, 1'b0);
        run_op("6/3", 6, 3, 1'b0);

        // Start pulsed while busy must be ignored.
        launch(14, 3);
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd5; divisor = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_ignore", W - 2, 1'b0);
        check_result("busy_ignore", 14, 3);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("busy_ignore extra_done", pulses, 0);
        check("busy_ignore idle_busy", busy, 0);

        // Reset in the middle of an operation abandons it silently.
        launch(14, 3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset quotient", quotient, 0);
        check("midreset remainder", remainder, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("midreset no_done", pulses, 0);
        run_op("7/2", 7, 2, 1'b0);

        // Back-to-back: new start accepted in the done cycle.
        launch(12, 5);
        wait_done("b2b first", W, 1'b0);
        check_result("b2b first", 12, 5);
        start = 1'b1; dividend = 4'd10; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b busy_restart", busy, 1);
        check("b2b quotient_kept", quotient, 2);
        check("b2b remainder_kept", remainder, 2);
        wait_done("b2b second", W, 1'b0);
        check_result("b2b second", 10, 3);

        // Exhaustive sweep of every operand pair.
        for (int dd = 0; dd < (1 << W); dd++) begin
            for (int dv = 0; dv < (1 << W); dv++) begin
                run_op($sformatf("sweep %0d/%0d", dd, dv), dd, dv, 1'b0);
            end
        end

        // Random operations with operands scrambled while the divider runs.
        for (int i = 0; i < 60; i++) begin
            int dd, dv;
            dd = int'($urandom_range((1 << W) - 1, 0));
            dv = int'($urandom_range((1 << W) - 1, 0));
            run_op($sformatf("rand %0d/%0d", dd, dv), dd, dv, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
